// File: rtl/gshare_predictor.sv
// gshare branch predictor: PHT of saturating counters indexed by PC xor global
// history, speculative GHR with ROB repair, and a circular return address stack.
module gshare_predictor #(
    parameter int PHT_IDX_W = 8,
    parameter int CTR_W     = 2,
    parameter int GHR_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid_from_fch,
    input  logic [31:0]      pc_from_fch,
    input  logic [31:0]      inst_from_fch,
    output logic             pred_jump_to_fch,
    output logic [31:0]      pred_target_to_fch,
    output logic [GHR_W-1:0] ghr_snapshot_to_fch,
    input  logic             upd_valid_from_rob,
    input  logic [31:0]      upd_pc_from_rob,
    input  logic             upd_taken_from_rob,
    input  logic [GHR_W-1:0] upd_ghr_from_rob,
    input  logic             upd_mispredict_from_rob
);
    localparam int PHT_SIZE = 1 << PHT_IDX_W;
    localparam int PTR_W    = $clog2(RAS_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    localparam logic [6:0]       OP_JAL   = 7'b1101111;
    localparam logic [6:0]       OP_JALR  = 7'b1100111;
    localparam logic [6:0]       OP_BR    = 7'b1100011;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c, input logic taken);
        logic [CTR_W-1:0] n;
        if (taken) begin
            n = (c == CTR_MAX) ? c : c + CTR_W'(1);
        end else begin
            n = (c == {CTR_W{1'b0}}) ? c : c - CTR_W'(1);
        end
        return n;
    endfunction

    logic [CTR_W-1:0]     pht_r [PHT_SIZE];
    logic [GHR_W-1:0]     ghr_r;
    logic [31:0]          ras_r [RAS_DEPTH];
    logic [PTR_W-1:0]     ras_ptr_r;
    logic [CNT_W-1:0]     ras_cnt_r;

    logic [PHT_IDX_W-1:0] rd_idx_s;
    logic [PHT_IDX_W-1:0] wr_idx_s;
    logic [CTR_W-1:0]     ctr_rd_s;
    logic [6:0]           opcode_s;
    logic [4:0]           rd_s;
    logic [4:0]           rs1_s;
    logic [31:0]          b_imm_s;
    logic [31:0]          j_imm_s;
    logic [31:0]          pc_plus4_s;
    logic [31:0]          ras_top_s;
    logic                 ras_nonempty_s;
    logic [PTR_W-1:0]     ras_ptr_inc_s;
    logic                 recover_s;
    logic                 jump_s;
    logic [31:0]          target_s;
    logic                 ghr_shift_s;
    logic                 ras_push_s;
    logic                 ras_pop_s;
    logic                 ras_repl_s;
    logic                 unused_bits_s;

    assign rd_idx_s       = pc_from_fch[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_r);
    assign wr_idx_s       = upd_pc_from_rob[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr_from_rob);
    assign ctr_rd_s       = pht_r[rd_idx_s];
    assign opcode_s       = inst_from_fch[6:0];
    assign rd_s           = inst_from_fch[11:7];
    assign rs1_s          = inst_from_fch[19:15];
    assign b_imm_s        = {{19{inst_from_fch[31]}}, inst_from_fch[31], inst_from_fch[7],
                             inst_from_fch[30:25], inst_from_fch[11:8], 1'b0};
    assign j_imm_s        = {{11{inst_from_fch[31]}}, inst_from_fch[31], inst_from_fch[19:12],
                             inst_from_fch[20], inst_from_fch[30:21], 1'b0};
    assign pc_plus4_s     = pc_from_fch + 32'd4;
    assign ras_top_s      = ras_r[ras_ptr_r];
    assign ras_nonempty_s = (ras_cnt_r != {CNT_W{1'b0}});
    assign ras_ptr_inc_s  = ras_ptr_r + PTR_W'(1);
    // A committed mispredict makes the same-cycle request wrong-path.
    assign recover_s      = upd_valid_from_rob & upd_mispredict_from_rob;
    assign unused_bits_s  = ^{upd_pc_from_rob[31:PHT_IDX_W+2], upd_pc_from_rob[1:0],
                              upd_ghr_from_rob[GHR_W-1]};

    assign pred_jump_to_fch    = jump_s;
    assign pred_target_to_fch  = target_s;
    assign ghr_snapshot_to_fch = ghr_r;

    // Decode the request and form the prediction plus requested GHR/RAS actions.
    always_comb begin
        jump_s      = 1'b0;
        target_s    = pc_plus4_s;
        ghr_shift_s = 1'b0;
        ras_push_s  = 1'b0;
        ras_pop_s   = 1'b0;
        ras_repl_s  = 1'b0;
        if (pred_valid_from_fch) begin
            case (opcode_s)
                OP_BR: begin
                    jump_s      = ctr_rd_s[CTR_W-1];
                    target_s    = pc_from_fch + b_imm_s;
                    ghr_shift_s = 1'b1;
                end
                OP_JAL: begin
                    jump_s     = 1'b1;
                    target_s   = pc_from_fch + j_imm_s;
                    ras_push_s = is_link(rd_s);
                end
                OP_JALR: begin
                    if (is_link(rs1_s) && !is_link(rd_s)) begin
                        if (ras_nonempty_s) begin
                            jump_s    = 1'b1;
                            target_s  = ras_top_s;
                            ras_pop_s = 1'b1;
                        end else begin
                            jump_s = 1'b0;
                        end
                    end else if (is_link(rd_s) && !is_link(rs1_s)) begin
                        ras_push_s = 1'b1;
                    end else if (is_link(rd_s) && is_link(rs1_s)) begin
                        // Coroutine swap: return through the top, then replace it.
                        if (ras_nonempty_s) begin
                            jump_s   = 1'b1;
                            target_s = ras_top_s;
                        end else begin
                            jump_s = 1'b0;
                        end
                        ras_repl_s = 1'b1;
                    end else begin
                        jump_s = 1'b0;
                    end
                end
                default: begin
                    jump_s = 1'b0;
                end
            endcase
        end else begin
            jump_s = 1'b0;
        end
    end

    // PHT counter update on every committed conditional branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht_r[i] <= CTR_INIT;
            end
        end else if (upd_valid_from_rob) begin
            pht_r[wr_idx_s] <= ctr_next(pht_r[wr_idx_s], upd_taken_from_rob);
        end
    end

    // Global history: ROB repair has priority over speculative shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_r <= {GHR_W{1'b0}};
        end else if (recover_s) begin
            ghr_r <= {upd_ghr_from_rob[GHR_W-2:0], upd_taken_from_rob};
        end else if (ghr_shift_s) begin
            ghr_r <= {ghr_r[GHR_W-2:0], jump_s};
        end
    end

    // Return address stack; a full push overwrites the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_r[i] <= 32'd0;
            end
            ras_ptr_r <= {PTR_W{1'b0}};
            ras_cnt_r <= {CNT_W{1'b0}};
        end else if (!recover_s) begin
            if (ras_push_s) begin
                ras_r[ras_ptr_inc_s] <= pc_plus4_s;
                ras_ptr_r            <= ras_ptr_inc_s;
                if (ras_cnt_r != RAS_FULL) begin
                    ras_cnt_r <= ras_cnt_r + CNT_W'(1);
                end
            end else if (ras_pop_s) begin
                ras_ptr_r <= ras_ptr_r - PTR_W'(1);
                ras_cnt_r <= ras_cnt_r - CNT_W'(1);
            end else if (ras_repl_s) begin
                ras_r[ras_ptr_r] <= pc_plus4_s;
                if (!ras_nonempty_s) begin
                    ras_cnt_r <= CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised branch predictor for the instruction fetcher. It replaces the single-level 2-bit table with a gshare pattern history table (PHT) whose counters have configurable width. It also keeps a speculative global history register (GHR) that the ROB repairs on a mispredict, and a return address stack (RAS) for call/return prediction. Predictions are combinational toward the fetcher; all state changes happen on the clock edge, except reset.

## Interface
- PHT_IDX_W, 8: PHT index bits; table holds 2^PHT_IDX_W counters.
- CTR_W, 2: saturating counter width, must be ≥2.
- GHR_W, 8: global history length, must be ≤ PHT_IDX_W.
- RAS_DEPTH, 4: return stack entries, must be a power of two ≥2.

- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- pred_valid_from_fch  in  1  prediction request this cycle.
- pc_from_fch  in  32  PC of the requesting instruction.
- inst_from_fch  in  32  instruction word.
- pred_jump_to_fch  out  1  predicted redirect.
- pred_target_to_fch  out  32  predicted absolute target.
- ghr_snapshot_to_fch  out  GHR_W  GHR value before this request; travels with the instruction to the ROB.
- upd_valid_from_rob  in  1  commit of a conditional branch.
- upd_pc_from_rob  in  32  PC of the committed branch.
- upd_taken_from_rob  in  1  actual outcome.
- upd_ghr_from_rob  in  GHR_W  snapshot returned with the branch.
- upd_mispredict_from_rob  in  1  committed branch was mispredicted; valid only with upd_valid_from_rob.

## Operation
- Decode uses inst[6:0]: JAL 1101111, JALR 1100111, BR 1100011. Link registers are x1 and x5.
- PHT index:
  - Read index = pc_from_fch[PHT_IDX_W+1:2] XOR zero-extended GHR.
  - Write index = upd_pc_from_rob[PHT_IDX_W+1:2] XOR zero-extended upd_ghr_from_rob.
- Counters are unsigned and saturate at 0 and 2^CTR_W−1. Taken moves the counter +1, not-taken moves it −1. The prediction is the counter MSB.
- Outputs when pred_valid_from_fch=0: jump=0, target=pc_from_fch+4.
- BR:
  - jump = counter MSB.
  - target = pc + sign-extended B-immediate, regardless of jump.
- JAL:
  - jump=1, target = pc + sign-extended J-immediate.
  - If rd is a link register, push pc+4.
- JALR:
  - Pop case: rs1 is a link register, rd is not, and the RAS is non-empty. Output jump=1, target = top entry, then pop.
  - Pop case with the RAS empty: jump=0, target=pc+4, no pop.
  - rd is a link register and rs1 is not: jump=0, target=pc+4, push pc+4.
  - Both rd and rs1 are link registers: target = top entry with jump=1 if the RAS is non-empty (else jump=0, target=pc+4). The top entry is then replaced with pc+4, and count becomes max(count,1).
  - All other JALR: jump=0, target=pc+4.
- Any other opcode: jump=0, target=pc+4.
- RAS structure:
  - Circular buffer with a top pointer and a count in 0..RAS_DEPTH.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop decrements count and moves the pointer back.
- GHR:
  - A valid BR request shifts in its prediction: GHR <= {GHR[GHR_W-2:0], pred}.
  - When upd_valid_from_rob and upd_mispredict_from_rob are both 1, GHR <= {upd_ghr[GHR_W-2:0], upd_taken}. This has priority.
  - In a mispredict cycle, the same-cycle request's GHR shift and RAS push/pop are suppressed; that request is wrong-path.
  - The RAS is not repaired on mispredict.
- PHT update happens whenever upd_valid_from_rob=1, independent of the mispredict flag.

## Timing
- Prediction has zero latency: all outputs are combinational from the request inputs and the current state.
- GHR, RAS and PHT writes take effect at the next posedge clk.
- A same-cycle read of a PHT entry being written returns the old value.
- rst, asynchronous, sets immediately:
  - every counter to 2^(CTR_W−1)−1 (weak not-taken);
  - GHR to 0;
  - RAS count to 0, pointer to 0, entries to 0.
- Outputs while rst is high follow the reset state: BR predicts 0, JALR predicts 0, ghr_snapshot_to_fch is 0.
- Deasserting rst mid-request causes no spurious state change before the next edge.

## Test plan
All cases use default parameters.
- Reset, then BR beq at PC 0x100 with imm +16 → jump 0, target 0x110, snapshot 0x00. GHR stays 0x00.
- Two taken updates: pc 0x100, upd_ghr 0 (index 0x40), counter 01→10→11; a BR request at 0x100 with GHR=0 now gives jump 1. Third taken update: counter stays 11. One not-taken update: counter 10, prediction still 1.
- Call/return:
  - JAL x1 at 0x200 with imm +0x40 → jump 1, target 0x240, push 0x204.
  - Next cycle, JALR x0,0(x1) → jump 1, target 0x204, RAS empty.
  - A further return → jump 0, target = its PC+4.
- RAS overflow: JAL x1 at 0x10, 0x20, 0x30, 0x40, 0x50. Five returns give targets 0x54, 0x44, 0x34, 0x24, then jump 0.
- Mispredict recovery: GHR=0xA5 with a same-cycle BR request; upd mispredict with upd_ghr 0x3C, taken 1 → next GHR 0x79, request shift suppressed.
- rst asserted between edges after pushes and history → GHR 0 and RAS empty without a clock edge. After release, the first return predicts jump 0.
